// File: rtl/col_cim_acc.sv
// rtl/col_cim_acc.sv - banked weight SRAM with bit-serial column compute-in-memory accumulator
module col_cim_acc #(
    parameter int NBANK = 4,
    parameter int NROW  = 4,
    parameter int DW    = 8,
    parameter int IW    = 8,
    parameter int AW    = 10,
    parameter int OW    = 8,
    parameter int SHIFT = 8,
    parameter int ACCW  = 24
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cs,
    input  logic                              web,
    input  logic [AW-1:0]                     a,
    input  logic [NBANK*DW-1:0]               d,
    output logic [NBANK*DW-1:0]               q,
    input  logic                              cim_valid,
    output logic                              cim_ready,
    input  logic [NBANK*NROW*IW-1:0]          cim_in,
    input  logic [AW-$clog2(NROW)-1:0]        cim_col,
    input  logic                              acc_clr,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OW-1:0]                     cim_out,
    output logic                              sat
);
    localparam int NIN  = NBANK * NROW;
    localparam int RW   = $clog2(NROW);
    localparam int CW   = AW - RW;
    localparam int KW   = $clog2(IW);
    localparam int CNTW = $clog2(NROW + IW) + 1;
    localparam int PSW  = DW + $clog2(NIN) + 1;
    localparam logic [CNTW-1:0] LAST_G = CNTW'(NROW - 1);
    localparam logic [CNTW-1:0] LAST_K = CNTW'(IW - 1);
    localparam logic [ACCW-1:0] OMAX   = ACCW'((2 ** OW) - 1);

    typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

    state_t             state, state_nx;
    logic               run;
    logic               accept;
    logic [DW-1:0]      mem [NBANK][2**AW];
    logic [DW-1:0]      w   [NIN];
    logic [IW-1:0]      act [NIN];
    logic [CW-1:0]      col;
    logic [CNTW-1:0]    cnt;
    logic [RW-1:0]      grp;
    logic [KW-1:0]      kbit;
    logic [ACCW-1:0]    acc, acc_nx, scaled;
    logic [PSW-1:0]     psum;

    assign grp    = cnt[RW-1:0];
    assign kbit   = cnt[KW-1:0];
    assign accept = cim_valid & cim_ready & cs & run;

    // Release from reset takes one edge to reach the accept path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cim_ready = 1'b0;
        case (state)
            IDLE: begin
                cim_ready = 1'b1;
                if (accept) state_nx = LOAD;
            end
            LOAD: if (cnt == LAST_G) state_nx = MAC;
            MAC:  if (cnt == LAST_K) state_nx = OUT;
            OUT:  if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Partial sum for one activation bit plane; wide enough to never overflow.
    always_comb begin
        psum = '0;
        for (int i = 0; i < NIN; i++)
            if (act[i][kbit]) psum = psum + PSW'(w[i]);
        acc_nx = acc + (ACCW'(psum) << kbit);
        scaled = acc_nx >> SHIFT;
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cs && !web)
            for (int b = 0; b < NBANK; b++) mem[b][a] <= d[b*DW +: DW];
        if (state == LOAD)
            for (int b = 0; b < NBANK; b++) w[b*NROW + int'(grp)] <= mem[b][{grp, col}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            acc       <= '0;
            col       <= '0;
            cnt       <= '0;
            cim_out   <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < NIN; i++) act[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs && web)
                        for (int b = 0; b < NBANK; b++) q[b*DW +: DW] <= mem[b][a];
                    if (accept) begin
                        for (int i = 0; i < NIN; i++) act[i] <= cim_in[i*IW +: IW];
                        col <= cim_col;
                        cnt <= '0;
                        if (acc_clr) acc <= '0;
                    end
                end
                LOAD: cnt <= (cnt == LAST_G) ? '0 : cnt + 1'b1;
                MAC: begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_K) begin
                        out_valid <= 1'b1;
                        sat       <= (scaled > OMAX);
                        cim_out   <= (scaled > OMAX) ? {OW{1'b1}} : scaled[OW-1:0];
                    end
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_col_cim_acc.sv
// tb/tb_col_cim_acc.sv - randomized self-checking bench for col_cim_acc
module tb_col_cim_acc;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         cs = 0, web = 1;
    logic [9:0]   a = '0;
    logic [31:0]  d = '0;
    logic [31:0]  q;
    logic         cim_valid = 0, cim_ready;
    logic [127:0] cim_in = '0;
    logic [7:0]   cim_col = '0;
    logic         acc_clr = 0;
    logic         out_valid, out_ready = 0;
    logic [7:0]   cim_out;
    logic         sat;

    int n_vec = 0, n_err = 0;
    logic [7:0]  bm [4][1024];
    longint      acc_m = 0;
    int          exp_out, exp_sat;

    always #5 clk = ~clk;

    col_cim_acc dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .web(web), .a(a), .d(d), .q(q),
        .cim_valid(cim_valid), .cim_ready(cim_ready), .cim_in(cim_in),
        .cim_col(cim_col), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .cim_out(cim_out), .sat(sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sram_write(input int addr, input logic [31:0] data);
        cs = 1; web = 0; a = addr[9:0]; d = data;
        @(posedge clk); #1;
        cs = 0; web = 1;
        for (int b = 0; b < 4; b++) bm[b][addr] = data[b*8 +: 8];
    endtask

    task automatic sram_read(input int addr, output logic [31:0] data);
        cs = 1; web = 1; a = addr[9:0];
        @(posedge clk); #1;
        cs = 0;
        data = q;
    endtask

    function automatic logic [31:0] model_word(input int addr);
        return {bm[3][addr], bm[2][addr], bm[1][addr], bm[0][addr]};
    endfunction

    // Dot product of the whole column as one plain sum, then scale and clamp.
    task automatic model_op(input logic clr, input int col, input logic [127:0] in_v);
        longint s = 0;
        longint sh;
        for (int i = 0; i < 16; i++)
            s += longint'(bm[i / 4][(i % 4) * 256 + col]) * longint'(in_v[i*8 +: 8]);
        if (clr) acc_m = 0;
        acc_m = (acc_m + s) % (64'd1 << 24);
        sh = acc_m / 256;
        exp_sat = (sh > 255) ? 1 : 0;
        exp_out = (sh > 255) ? 255 : int'(sh);
    endtask

    task automatic start_op(input logic clr, input int col, input logic [127:0] in_v);
        model_op(clr, col, in_v);
        cim_valid = 1; cs = 1; web = 1; cim_in = in_v; cim_col = col[7:0]; acc_clr = clr;
        @(posedge clk); #1;
        cim_valid = 0; acc_clr = $urandom_range(0, 1);
    endtask

    task automatic finish_op(input int stall, input bit poke);
        int n = 0;
        while (!out_valid && n < 40) begin
            cim_in  = {$urandom, $urandom, $urandom, $urandom};
            cim_col = 8'($urandom);
            cs      = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        cs = 0;
        check("latency", n, 12);
        check("cim_out", cim_out, exp_out);
        check("sat", sat, exp_sat);
        for (int s = 0; s < stall; s++) begin
            if (poke) begin cs = 1; web = 0; a = 10'h003; d = 32'hAAAAAAAA; end
            @(posedge clk); #1;
            check("hold_out", cim_out, exp_out);
            check("hold_valid", out_valid, 1);
            check("hold_ready", cim_ready, 0);
        end
        cs = 0; web = 1;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check("done_valid", out_valid, 0);
        check("done_ready", cim_ready, 1);
    endtask

    initial begin
        logic [31:0]  rd;
        logic [127:0] ff_in;
        ff_in = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", q, 0);
        check("rst_out", cim_out, 0);
        check("rst_sat", sat, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ready", cim_ready, 1);
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;

        sram_write(3, 32'h44332211);
        sram_write(4, 32'h88776655);
        sram_write(3, 32'h4433225A);
        sram_read(3, rd);
        check("rd_003", rd, model_word(3));
        sram_read(4, rd);
        check("rd_004", rd, model_word(4));

        for (int g = 0; g < 4; g++) sram_write(g * 256, 32'h01010101);
        for (int g = 0; g < 4; g++) sram_write(g * 256 + 1, 32'hFFFFFFFF);

        start_op(1, 0, ff_in); check("acc_4080", 32'(acc_m), 4080); finish_op(0, 0);
        check("ones_out", cim_out, 15);
        start_op(0, 0, ff_in); finish_op(0, 0);
        check("accum_out", cim_out, 31);
        start_op(1, 0, ff_in); finish_op(0, 0);
        check("clr_out", cim_out, 15);
        start_op(1, 1, ff_in); check("acc_max", 32'(acc_m), 1040400); finish_op(0, 0);
        check("sat_flag", sat, 1);

        start_op(1, 0, ff_in); finish_op(5, 1);
        sram_read(3, rd);
        check("poke_ignored", rd, 32'h4433225A);

        start_op(1, 1, ff_in);
        repeat (7) @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_ready", cim_ready, 1);
        acc_m = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_op(0, 0, ff_in);
        cim_valid = 1; cs = 1; web = 1; cim_in = ff_in; cim_col = 8'd0; acc_clr = 0;
        @(posedge clk); #1;
        check("sync_edge1", cim_ready, 1);
        @(posedge clk); #1;
        check("sync_edge2", cim_ready, 0);
        cim_valid = 0;
        repeat (1) @(posedge clk);
        #1;
        begin
            int n = 1;
            while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
            check("post_rst_lat", n, 12);
        end
        check("post_rst_out", cim_out, 15);
        out_ready = 1; @(posedge clk); #1; out_ready = 0;

        for (int op = 0; op < 1000; op++) begin
            int col;
            col = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0)
                for (int g = 0; g < 4; g++) sram_write(g * 256 + col, $urandom);
            if ($urandom_range(0, 7) == 0) begin
                int ad;
                ad = $urandom_range(0, 1023);
                sram_read(ad, rd);
                check("rand_rd", rd, model_word(ad));
            end
            start_op(1'($urandom), col, {$urandom, $urandom, $urandom, $urandom});
            finish_op($urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
